// File: rtl/transpose_pkg.sv
// Shared types and helpers for the streaming matrix transposer.
// Latency: none (declarations only).
// Backpressure: not applicable.
`timescale 1ns/1ps
package transpose_pkg;

  // Fill the buffer row-major, then drain it column-major.
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Index width for a range of n entries; a single-entry range still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transpose_buf.sv
// M x N element store with one write port and one combinational read port.
// Latency: write visible on the read port the cycle after i_we; read is combinational.
// Backpressure: none; the owner decides when to write and what to read.
`timescale 1ns/1ps
module transpose_buf
  import transpose_pkg::*;
#(
  parameter int M          = 6,
  parameter int N          = 6,
  parameter int DATA_WIDTH = 8,
  localparam int RW        = idx_w(M),
  localparam int CW        = idx_w(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [RW-1:0]         i_wr_row,
  input  logic [CW-1:0]         i_wr_col,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [RW-1:0]         i_rd_row,
  input  logic [CW-1:0]         i_rd_col,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [M][N];

  // Clear every element on reset so no stale matrix can ever be read out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (i_we) begin
      r_mem[i_wr_row][i_wr_col] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_rd_row][i_rd_col];

endmodule

// File: rtl/transpose_stream.sv
// Streaming M x N transposer: loads row-major, emits column-major (optional out_last via TRANSPOSE_LAST_EN).
// Latency: first out_valid the cycle after the last input accept; in_ready returns the cycle after the last output.
// Backpressure: in_ready low for the whole drain; out_ready low holds indices and out_data indefinitely.
`timescale 1ns/1ps
module transpose_stream
  import transpose_pkg::*;
#(
  parameter int M          = 6,
  parameter int N          = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef TRANSPOSE_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int RW = idx_w(M);
  localparam int CW = idx_w(N);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);

  state_t                r_state;
  logic [RW-1:0]         r_wr_row;
  logic [CW-1:0]         r_wr_col;
  logic [RW-1:0]         r_rd_row;
  logic [CW-1:0]         r_rd_col;
  logic                  w_accept;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Handshake flags are pure decodes of the state register, so they drop straight away on reset.
  assign in_ready  = (r_state == FILL);
  assign out_valid = (r_state == DRAIN);
  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = out_valid & out_ready;

  // Outside the drain the output bus is parked at zero rather than exposing a half-filled buffer.
  assign out_data  = out_valid ? w_rdata : '0;

`ifdef TRANSPOSE_LAST_EN
  assign out_last  = out_valid && (r_rd_col == COL_LAST) && (r_rd_row == ROW_LAST);
`else
  // No end-of-matrix marker in this build.
`endif

  transpose_buf #(
    .M          (M),
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_accept),
    .i_wr_row (r_wr_row),
    .i_wr_col (r_wr_col),
    .i_wdata  (in_data),
    .i_rd_row (r_rd_row),
    .i_rd_col (r_rd_col),
    .o_rdata  (w_rdata)
  );

  // Phase FSM: write walks columns inside rows, read walks rows inside columns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FILL;
      r_wr_row <= '0;
      r_wr_col <= '0;
      r_rd_row <= '0;
      r_rd_col <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (r_wr_col == COL_LAST) begin
              r_wr_col <= '0;
              if (r_wr_row == ROW_LAST) begin
                r_wr_row <= '0;
                r_state  <= DRAIN;
              end else begin
                r_wr_row <= r_wr_row + 1'b1;
              end
            end else begin
              r_wr_col <= r_wr_col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_xfer) begin
            if (r_rd_row == ROW_LAST) begin
              r_rd_row <= '0;
              if (r_rd_col == COL_LAST) begin
                r_rd_col <= '0;
                r_state  <= FILL;
              end else begin
                r_rd_col <= r_rd_col + 1'b1;
              end
            end else begin
              r_rd_row <= r_rd_row + 1'b1;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_transpose_stream.sv
// Directed bench for transpose_stream: 6x6, 2x3 and 1x4 instances on a shared clock and reset.
// Latency: checks first out_valid one cycle after the last accept and in_ready one cycle after the last transfer.
// Backpressure: drives out_ready patterns and in_valid during drain.
`timescale 1ns/1ps
module tb_transpose_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
`ifdef TRANSPOSE_LAST_EN
  logic       a_out_last, b_out_last, c_out_last;
`endif

  int vecs = 0;
  int errs = 0;

  transpose_stream #(.M(6), .N(6), .DATA_WIDTH(8)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data)
`ifdef TRANSPOSE_LAST_EN
    , .out_last (a_out_last)
`endif
  );

  transpose_stream #(.M(2), .N(3), .DATA_WIDTH(8)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data)
`ifdef TRANSPOSE_LAST_EN
    , .out_last (b_out_last)
`endif
  );

  transpose_stream #(.M(1), .N(4), .DATA_WIDTH(8)) u_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (c_in_valid),
    .in_ready  (c_in_ready),
    .in_data   (c_in_data),
    .out_valid (c_out_valid),
    .out_ready (c_out_ready),
    .out_data  (c_out_data)
`ifdef TRANSPOSE_LAST_EN
    , .out_last (c_out_last)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
    #12;
    vecs++;
    if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
      errs++; $display("FAIL reset_in_ready got=%b want=111", {a_in_ready, b_in_ready, c_in_ready});
    end
    vecs++;
    if ({a_out_valid, b_out_valid, c_out_valid} !== 3'b000) begin
      errs++; $display("FAIL reset_out_valid got=%b want=000", {a_out_valid, b_out_valid, c_out_valid});
    end
    vecs++;
    if ({a_out_data, b_out_data, c_out_data} !== 24'h0) begin
      errs++; $display("FAIL reset_out_data got=%h want=000000", {a_out_data, b_out_data, c_out_data});
    end
`ifdef TRANSPOSE_LAST_EN
    vecs++;
    if ({a_out_last, b_out_last, c_out_last} !== 3'b000) begin
      errs++; $display("FAIL reset_out_last got=%b want=000", {a_out_last, b_out_last, c_out_last});
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
      errs++; $display("FAIL post_reset_in_ready got=%b want=111", {a_in_ready, b_in_ready, c_in_ready});
    end
  endtask

  // One 2x3 matrix base..base+5 through u_b; must be entered and leaves on a negedge.
  task automatic run_b(input string nm, input int base, input bit bp, input bit junk);
    int k = 0, n = 0, cyc = 0, last_acc = -1, first_ov = -1, nrdy = 0, dcyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'h0;
    logic [7:0] expv;
    while (n < 6 && cyc < 80) begin
      b_in_valid  = (k < 6) || junk;
      b_in_data   = (k < 6) ? 8'(base + k) : 8'hFF;
      b_out_ready = bp ? ((dcyc % 4 == 0) || (dcyc % 4 == 3)) : 1'b1;
      #1;
      if (cyc == 0) begin
        vecs++;
        if (b_in_ready !== 1'b1) begin
          errs++; $display("FAIL %s_start_in_ready got=%b want=1", nm, b_in_ready);
        end
      end
      if (b_out_valid === 1'b1) begin
        expv = 8'(base + (n % 2) * 3 + n / 2);
        vecs++;
        if (b_out_data !== expv) begin
          errs++; $display("FAIL %s_beat%0d got=%0d want=%0d", nm, n, b_out_data, expv);
        end
        if (prev_stall) begin
          vecs++;
          if (b_out_data !== prev_dat) begin
            errs++; $display("FAIL %s_hold got=%0d want=%0d", nm, b_out_data, prev_dat);
          end
        end
`ifdef TRANSPOSE_LAST_EN
        vecs++;
        if (b_out_last !== (n == 5)) begin
          errs++; $display("FAIL %s_last%0d got=%b want=%b", nm, n, b_out_last, (n == 5));
        end
`endif
        if (first_ov < 0) begin
          first_ov = cyc;
          vecs++;
          if (cyc != last_acc + 1) begin
            errs++; $display("FAIL %s_first_valid_cycle got=%0d want=%0d", nm, cyc, last_acc + 1);
          end
        end
        prev_stall = !b_out_ready;
        prev_dat   = b_out_data;
        if (b_out_ready) n++;
        dcyc++;
      end else begin
        prev_stall = 1'b0;
      end
      if (b_in_ready !== 1'b1) nrdy++;
      if (b_in_valid && b_in_ready) begin
        k++;
        last_acc = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    vecs++;
    if (n != 6) begin
      errs++; $display("FAIL %s_timeout got=%0d beats want=6", nm, n);
    end
    if (!bp) begin
      vecs++;
      if (nrdy != 6) begin
        errs++; $display("FAIL %s_in_ready_low_cycles got=%0d want=6", nm, nrdy);
      end
    end
  endtask

  task automatic test_basic_2x3();
    run_b("basic", 1, 1'b0, 1'b0);
    b_in_valid = 0;
  endtask

  task automatic test_backpressure();
    run_b("bp", 1, 1'b1, 1'b0);
    b_in_valid = 0;
  endtask

  task automatic test_reset_mid_op();
    // Three elements of a partial matrix, then an asynchronous reset.
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1; b_in_data = 8'(50 + i); b_out_ready = 1;
      @(negedge clk);
    end
    b_in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({b_in_ready, b_out_valid} !== 2'b10) begin
      errs++; $display("FAIL midfill_reset got=%b want=10", {b_in_ready, b_out_valid});
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    // Full matrix, one transfer into the drain, then reset between clock edges.
    for (int i = 0; i < 6; i++) begin
      b_in_valid = 1; b_in_data = 8'(20 + i); b_out_ready = 1;
      @(negedge clk);
    end
    b_in_valid = 0;
    #1;
    vecs++;
    if (b_out_valid !== 1'b1) begin
      errs++; $display("FAIL middrain_pre got=%b want=1", b_out_valid);
    end
    @(negedge clk);
    b_out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({b_in_ready, b_out_valid, b_out_data} !== {2'b10, 8'h00}) begin
      errs++; $display("FAIL middrain_reset got=%b_%h want=10_00", {b_in_ready, b_out_valid}, b_out_data);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_b("after_reset", 10, 1'b0, 1'b0);
    b_in_valid = 0;
  endtask

  task automatic test_drain_input_back_to_back();
    run_b("junk", 1, 1'b0, 1'b1);
    run_b("b2b", 7, 1'b0, 1'b0);
    b_in_valid = 0;
  endtask

  task automatic test_6x6();
    int k = 0, n = 0, cyc = 0;
    logic [7:0] expv;
    while (n < 36 && cyc < 200) begin
      a_in_valid  = (k < 36);
      a_in_data   = 8'(k);
      a_out_ready = 1;
      #1;
      if (a_out_valid === 1'b1) begin
        expv = 8'((n % 6) * 6 + n / 6);
        vecs++;
        if (a_out_data !== expv) begin
          errs++; $display("FAIL m6x6_beat%0d got=%0d want=%0d", n, a_out_data, expv);
        end
`ifdef TRANSPOSE_LAST_EN
        vecs++;
        if (a_out_last !== (n == 35)) begin
          errs++; $display("FAIL m6x6_last%0d got=%b want=%b", n, a_out_last, (n == 35));
        end
`endif
        n++;
      end
      if (a_in_valid && a_in_ready) k++;
      cyc++;
      @(negedge clk);
    end
    a_in_valid = 0;
    vecs++;
    if (n != 36) begin
      errs++; $display("FAIL m6x6_timeout got=%0d beats want=36", n);
    end
  endtask

  task automatic test_degenerate_1x4();
    logic [7:0] seq [4];
    int k = 0, n = 0, cyc = 0, nrdy = 0;
    seq[0] = 8'd9; seq[1] = 8'd8; seq[2] = 8'd7; seq[3] = 8'd6;
    // Two matrices back to back to exercise the phase alternation.
    while (n < 8 && cyc < 60) begin
      c_in_valid  = (k < 8);
      c_in_data   = seq[k % 4];
      c_out_ready = 1;
      #1;
      vecs++;
      if (c_in_ready === c_out_valid) begin
        errs++; $display("FAIL m1x4_phase cyc%0d got=%b%b want=complementary", cyc, c_in_ready, c_out_valid);
      end
      if (c_out_valid === 1'b1) begin
        vecs++;
        if (c_out_data !== seq[n % 4]) begin
          errs++; $display("FAIL m1x4_beat%0d got=%0d want=%0d", n, c_out_data, seq[n % 4]);
        end
`ifdef TRANSPOSE_LAST_EN
        vecs++;
        if (c_out_last !== (n % 4 == 3)) begin
          errs++; $display("FAIL m1x4_last%0d got=%b want=%b", n, c_out_last, (n % 4 == 3));
        end
`endif
        n++;
      end
      if (c_in_ready !== 1'b1) nrdy++;
      if (c_in_valid && c_in_ready) k++;
      cyc++;
      @(negedge clk);
    end
    c_in_valid = 0;
    vecs++;
    if (n != 8 || nrdy != 8) begin
      errs++; $display("FAIL m1x4_count got=%0d beats %0d busy want=8 8", n, nrdy);
    end
    #1;
    vecs++;
    if (c_in_ready !== 1'b1) begin
      errs++; $display("FAIL m1x4_final_in_ready got=%b want=1", c_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_2x3();
    test_backpressure();
    test_reset_mid_op();
    test_drain_input_back_to_back();
    test_6x6();
    test_degenerate_1x4();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
